axi_lite_arbiter: RTL and testbench
===================================

// Module: axi_lite_arbiter
// PURPOSE
// 2-master -> 1-slave AXI4-Lite arbiter. Instruction fetch (m0) and load/store (m1) share the single
// core-side port of the memory/UART router. One transaction (read or write) is in flight at a time.
// Round-robin grant between the two masters; responses are routed back only to the granted master.
// PARAMETERS
// ADDR_W  32  address width (araddr/awaddr)
// DATA_W  32  data width (rdata/wdata); wstrb width = DATA_W/8
// PORTS  (mX = m0 and m1; every mX_ line exists once per master)
// clk              in   1         clock; all state updates on posedge
// rst              in   1         asynchronous, active-high reset
// mX_axi_araddr    in   ADDR_W    master read address
// mX_axi_arvalid   in   1         master read request
// mX_axi_arready   out  1         read address accepted
// mX_axi_rdata     out  DATA_W    read data
// mX_axi_rresp     out  2         read response
// mX_axi_rvalid    out  1         read data valid
// mX_axi_rready    in   1         master accepts read data
// mX_axi_awaddr    in   ADDR_W    master write address
// mX_axi_awvalid   in   1         master write request
// mX_axi_awready   out  1         write address accepted
// mX_axi_wdata     in   DATA_W    write data
// mX_axi_wstrb     in   DATA_W/8  byte strobes
// mX_axi_wvalid    in   1         write data valid
// mX_axi_wready    out  1         write data accepted
// mX_axi_bresp     out  2         write response
// mX_axi_bvalid    out  1         write response valid
// mX_axi_bready    in   1         master accepts write response
// s_axi_*          mirror of one master set, opposite directions; connects to the router core port
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, grant=0, last_grant=1, aw_done=w_done=0.
//   All valid/ready outputs on both sides are 0. Data/addr/resp outputs are 0.
// - State register: IDLE, R_ADDR, R_DATA, W_ADDR, W_RESP. All forwarding is combinational from state+grant.
// - Outputs are 0 on the non-granted master, and on every channel not active in the current state.
// - IDLE: a master requests if arvalid|awvalid.
//   - If both masters request, grant the one != last_grant; otherwise grant the single requester.
//   - Within the granted master, awvalid wins over arvalid, so a store is ordered before a later load.
//   - Next state W_ADDR or R_ADDR. Request seen at cycle N -> slave valid at N+1.
//   - Minimum 1 IDLE cycle between transactions.
// - R_ADDR: s_arvalid=mG_arvalid, s_araddr=mG_araddr, mG_arready=s_arready.
//   - On s_arvalid&s_arready -> R_DATA.
// - R_DATA: mG_rvalid/rdata/rresp=s_*, s_rready=mG_rready.
//   - On handshake -> IDLE; last_grant<=grant.
// - W_ADDR: AW and W channels are forwarded independently; aw_done/w_done set on each handshake.
//   - Once a channel is done, its slave valid and master ready are forced to 0.
//   - When both are done (same cycle allowed) -> W_RESP; clear flags.
// - W_RESP: mG_bvalid/bresp=s_*, s_bready=mG_bready.
//   - On handshake -> IDLE; last_grant<=grant.
// - Resp codes pass through unmodified (no error generation).
// - Slave back-pressure: stay in the current state indefinitely; no timeout.
// - Reset mid-transaction: the transaction is abandoned. The slave shares rst and is cleared too.
//   The first request after reset is served normally.
// - Masters must hold valid until handshake (AXI rule); withdrawal is not supported.
// TESTING
// 1. m0 arvalid addr 0x10, slave returns 0xDEADBEEF/OKAY -> s_arvalid at N+1 with 0x10;
//    m0 gets 0xDEADBEEF; m1 rvalid stays 0.
// 2. m0,m1 arvalid same cycle, repeated 4 rounds after reset -> grant order m0,m1,m0,m1.
// 3. m1 AW 0xFF000004, W 0x41/wstrb 0x1 three cycles later, slave bresp 2'b10
//    -> AW then W forwarded; m1_bresp=2'b10; back to IDLE.
// 4. m1 arvalid+awvalid together -> write completes (bvalid) before s_arvalid rises.
// 5. rst pulsed during R_DATA -> all valid/ready 0 in the same cycle;
//    a following m0 read of 0x20 completes normally.
// 6. s_arready low 5 cycles, then m0_rready low 3 cycles
//    -> single ar handshake, rvalid/rdata held stable, exactly one transfer.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_arbiter
//   Two AXI4-Lite masters (m0 = instruction fetch, m1 = load/store) share one
//   AXI4-Lite slave port. Exactly one transaction (read or write) is in flight
//   at a time. Grant is round-robin when both masters request; responses are
//   returned only to the granted master.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   m0_axi_*         master 0 AXI4-Lite slave-side port (AR, R, AW, W, B)
//   m1_axi_*         master 1 AXI4-Lite slave-side port (AR, R, AW, W, B)
//   s_axi_*          shared master-side port towards the router core port
//   dbg_state        current FSM state (IDLE=0, R_ADDR=1, R_DATA=2,
//                    W_ADDR=3, W_RESP=4)
//
// Handshake semantics: every channel transfers on a cycle where valid and
// ready are both high at posedge clk. Masters hold valid (and payload) stable
// until the handshake. The arbiter never creates or drops a handshake: in the
// active state it wires the granted master's channel straight through, and
// every other channel (and the other master) sees 0.
// -----------------------------------------------------------------------------
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   m0_axi_araddr,
    input  logic                m0_axi_arvalid,
    output logic                m0_axi_arready,
    output logic [DATA_W-1:0]   m0_axi_rdata,
    output logic [1:0]          m0_axi_rresp,
    output logic                m0_axi_rvalid,
    input  logic                m0_axi_rready,
    input  logic [ADDR_W-1:0]   m0_axi_awaddr,
    input  logic                m0_axi_awvalid,
    output logic                m0_axi_awready,
    input  logic [DATA_W-1:0]   m0_axi_wdata,
    input  logic [DATA_W/8-1:0] m0_axi_wstrb,
    input  logic                m0_axi_wvalid,
    output logic                m0_axi_wready,
    output logic [1:0]          m0_axi_bresp,
    output logic                m0_axi_bvalid,
    input  logic                m0_axi_bready,

    input  logic [ADDR_W-1:0]   m1_axi_araddr,
    input  logic                m1_axi_arvalid,
    output logic                m1_axi_arready,
    output logic [DATA_W-1:0]   m1_axi_rdata,
    output logic [1:0]          m1_axi_rresp,
    output logic                m1_axi_rvalid,
    input  logic                m1_axi_rready,
    input  logic [ADDR_W-1:0]   m1_axi_awaddr,
    input  logic                m1_axi_awvalid,
    output logic                m1_axi_awready,
    input  logic [DATA_W-1:0]   m1_axi_wdata,
    input  logic [DATA_W/8-1:0] m1_axi_wstrb,
    input  logic                m1_axi_wvalid,
    output logic                m1_axi_wready,
    output logic [1:0]          m1_axi_bresp,
    output logic                m1_axi_bvalid,
    input  logic                m1_axi_bready,

    output logic [ADDR_W-1:0]   s_axi_araddr,
    output logic                s_axi_arvalid,
    input  logic                s_axi_arready,
    input  logic [DATA_W-1:0]   s_axi_rdata,
    input  logic [1:0]          s_axi_rresp,
    input  logic                s_axi_rvalid,
    output logic                s_axi_rready,
    output logic [ADDR_W-1:0]   s_axi_awaddr,
    output logic                s_axi_awvalid,
    input  logic                s_axi_awready,
    output logic [DATA_W-1:0]   s_axi_wdata,
    output logic [DATA_W/8-1:0] s_axi_wstrb,
    output logic                s_axi_wvalid,
    input  logic                s_axi_wready,
    input  logic [1:0]          s_axi_bresp,
    input  logic                s_axi_bvalid,
    output logic                s_axi_bready,

    output logic [2:0]          dbg_state
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R_ADDR = 3'd1,
        R_DATA = 3'd2,
        W_ADDR = 3'd3,
        W_RESP = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;           // 0 = m0, 1 = m1
    logic   last_grant_q, last_grant_d; // master served by the last completed transaction
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    assign dbg_state = state_q;

    // Granted master's inputs, selected once so the forwarding logic is
    // written a single time.
    logic [ADDR_W-1:0] g_araddr, g_awaddr;
    logic [DATA_W-1:0] g_wdata;
    logic [STRB_W-1:0] g_wstrb;
    logic              g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;

    assign g_araddr  = grant_q ? m1_axi_araddr  : m0_axi_araddr;
    assign g_arvalid = grant_q ? m1_axi_arvalid : m0_axi_arvalid;
    assign g_rready  = grant_q ? m1_axi_rready  : m0_axi_rready;
    assign g_awaddr  = grant_q ? m1_axi_awaddr  : m0_axi_awaddr;
    assign g_awvalid = grant_q ? m1_axi_awvalid : m0_axi_awvalid;
    assign g_wdata   = grant_q ? m1_axi_wdata   : m0_axi_wdata;
    assign g_wstrb   = grant_q ? m1_axi_wstrb   : m0_axi_wstrb;
    assign g_wvalid  = grant_q ? m1_axi_wvalid  : m0_axi_wvalid;
    assign g_bready  = grant_q ? m1_axi_bready  : m0_axi_bready;

    // Slave-to-master values before demux onto the granted master.
    logic              fwd_arready, fwd_awready, fwd_wready;
    logic              fwd_rvalid, fwd_bvalid;
    logic [DATA_W-1:0] fwd_rdata;
    logic [1:0]        fwd_rresp, fwd_bresp;

    always_comb begin
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        fwd_arready   = 1'b0;
        fwd_awready   = 1'b0;
        fwd_wready    = 1'b0;
        fwd_rvalid    = 1'b0;
        fwd_rdata     = '0;
        fwd_rresp     = 2'b00;
        fwd_bvalid    = 1'b0;
        fwd_bresp     = 2'b00;

        case (state_q)
            R_ADDR: begin
                s_axi_arvalid = g_arvalid;
                s_axi_araddr  = g_araddr;
                fwd_arready   = s_axi_arready;
            end
            R_DATA: begin
                fwd_rvalid   = s_axi_rvalid;
                fwd_rdata    = s_axi_rdata;
                fwd_rresp    = s_axi_rresp;
                s_axi_rready = g_rready;
            end
            W_ADDR: begin
                // A channel that has already handshaken is closed off so the
                // slave cannot see a second address or data beat.
                if (!aw_done_q) begin
                    s_axi_awvalid = g_awvalid;
                    s_axi_awaddr  = g_awaddr;
                    fwd_awready   = s_axi_awready;
                end
                if (!w_done_q) begin
                    s_axi_wvalid = g_wvalid;
                    s_axi_wdata  = g_wdata;
                    s_axi_wstrb  = g_wstrb;
                    fwd_wready   = s_axi_wready;
                end
            end
            W_RESP: begin
                fwd_bvalid   = s_axi_bvalid;
                fwd_bresp    = s_axi_bresp;
                s_axi_bready = g_bready;
            end
            default: ;
        endcase
    end

    // Demux onto the granted master; the other master sees all zeros.
    assign m0_axi_arready = fwd_arready & ~grant_q;
    assign m1_axi_arready = fwd_arready &  grant_q;
    assign m0_axi_awready = fwd_awready & ~grant_q;
    assign m1_axi_awready = fwd_awready &  grant_q;
    assign m0_axi_wready  = fwd_wready  & ~grant_q;
    assign m1_axi_wready  = fwd_wready  &  grant_q;
    assign m0_axi_rvalid  = fwd_rvalid  & ~grant_q;
    assign m1_axi_rvalid  = fwd_rvalid  &  grant_q;
    assign m0_axi_bvalid  = fwd_bvalid  & ~grant_q;
    assign m1_axi_bvalid  = fwd_bvalid  &  grant_q;
    assign m0_axi_rdata   = grant_q ? '0    : fwd_rdata;
    assign m1_axi_rdata   = grant_q ? fwd_rdata : '0;
    assign m0_axi_rresp   = grant_q ? 2'b00 : fwd_rresp;
    assign m1_axi_rresp   = grant_q ? fwd_rresp : 2'b00;
    assign m0_axi_bresp   = grant_q ? 2'b00 : fwd_bresp;
    assign m1_axi_bresp   = grant_q ? fwd_bresp : 2'b00;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic req0, req1, sel;

    // Slave-side valid/ready are already gated by state, so these are only
    // ever high in the state that owns the channel.
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign r_hs  = s_axi_rvalid  & s_axi_rready;
    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid  & s_axi_wready;
    assign b_hs  = s_axi_bvalid  & s_axi_bready;

    assign req0 = m0_axi_arvalid | m0_axi_awvalid;
    assign req1 = m1_axi_arvalid | m1_axi_awvalid;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        sel          = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to the master not served last time.
                    sel     = (req0 && req1) ? ~last_grant_q : req1;
                    grant_d = sel;
                    // A pending store is issued before a load from the same
                    // master so the load observes it.
                    if (sel ? m1_axi_awvalid : m0_axi_awvalid)
                        state_d = W_ADDR;
                    else
                        state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) state_d = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            W_ADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = W_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_arbiter
//   Directed bench for axi_lite_arbiter. A table of request patterns with
//   hand-computed grant/route results is replayed through a bench-driven
//   slave, followed by hand-written sequences for split AW/W timing, reset
//   during a read, and slave/master back-pressure.
// -----------------------------------------------------------------------------
module tb_axi_lite_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_axi_araddr, m1_axi_araddr, m0_axi_awaddr, m1_axi_awaddr;
    logic        m0_axi_arvalid, m1_axi_arvalid, m0_axi_arready, m1_axi_arready;
    logic [31:0] m0_axi_rdata, m1_axi_rdata;
    logic [1:0]  m0_axi_rresp, m1_axi_rresp, m0_axi_bresp, m1_axi_bresp;
    logic        m0_axi_rvalid, m1_axi_rvalid, m0_axi_rready, m1_axi_rready;
    logic        m0_axi_awvalid, m1_axi_awvalid, m0_axi_awready, m1_axi_awready;
    logic [31:0] m0_axi_wdata, m1_axi_wdata;
    logic [3:0]  m0_axi_wstrb, m1_axi_wstrb;
    logic        m0_axi_wvalid, m1_axi_wvalid, m0_axi_wready, m1_axi_wready;
    logic        m0_axi_bvalid, m1_axi_bvalid, m0_axi_bready, m1_axi_bready;

    logic [31:0] s_axi_araddr, s_axi_awaddr, s_axi_rdata, s_axi_wdata;
    logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_rresp, s_axi_bresp;
    logic [3:0]  s_axi_wstrb;
    logic [2:0]  dbg_state;

    axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m0_axi_araddr(m0_axi_araddr), .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready),
        .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp), .m0_axi_rvalid(m0_axi_rvalid),
        .m0_axi_rready(m0_axi_rready), .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awvalid(m0_axi_awvalid),
        .m0_axi_awready(m0_axi_awready), .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb),
        .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(m0_axi_wready), .m0_axi_bresp(m0_axi_bresp),
        .m0_axi_bvalid(m0_axi_bvalid), .m0_axi_bready(m0_axi_bready),
        .m1_axi_araddr(m1_axi_araddr), .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready),
        .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp), .m1_axi_rvalid(m1_axi_rvalid),
        .m1_axi_rready(m1_axi_rready), .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awvalid(m1_axi_awvalid),
        .m1_axi_awready(m1_axi_awready), .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb),
        .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready), .m1_axi_bresp(m1_axi_bresp),
        .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Handshake counters on the slave side.
    int ar_cnt = 0;
    int r_cnt  = 0;
    always @(posedge clk) begin
        if (s_axi_arvalid && s_axi_arready) ar_cnt <= ar_cnt + 1;
        if (s_axi_rvalid  && s_axi_rready)  r_cnt  <= r_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        m0_ar;
        logic        m0_aw;
        logic        m1_ar;
        logic        m1_aw;
        logic        exp_g;     // master expected to win
        logic        exp_wr;    // expected transaction is a write
        logic [31:0] exp_addr;  // address expected on the slave
        logic [31:0] rdata;     // slave read data
        logic [1:0]  resp;      // slave rresp/bresp
    } vec_t;

    vec_t vecs[12];

    task automatic drop_masters();
        m0_axi_arvalid = 1'b0; m0_axi_awvalid = 1'b0; m0_axi_wvalid = 1'b0;
        m1_axi_arvalid = 1'b0; m1_axi_awvalid = 1'b0; m1_axi_wvalid = 1'b0;
    endtask

    task automatic clear_slave();
        s_axi_arready = 1'b0; s_axi_awready = 1'b0; s_axi_wready = 1'b0;
        s_axi_rvalid = 1'b0; s_axi_rdata = '0; s_axi_rresp = 2'b00;
        s_axi_bvalid = 1'b0; s_axi_bresp = 2'b00;
    endtask

    // Apply one request pattern and serve whatever transaction is granted.
    task automatic run_vec(input vec_t v, input int idx);
        logic g;
        g = v.exp_g;
        @(negedge clk);
        m0_axi_arvalid = v.m0_ar; m0_axi_awvalid = v.m0_aw; m0_axi_wvalid = v.m0_aw;
        m1_axi_arvalid = v.m1_ar; m1_axi_awvalid = v.m1_aw; m1_axi_wvalid = v.m1_aw;
        #1;
        check($sformatf("v%0d_idle_s_valid", idx), {29'd0, s_axi_arvalid, s_axi_awvalid, s_axi_wvalid}, 32'd0);
        @(posedge clk); #1;
        if (v.exp_wr) begin
            check($sformatf("v%0d_state", idx), {29'd0, dbg_state}, 32'd3);
            check($sformatf("v%0d_s_awvalid", idx), {31'd0, s_axi_awvalid}, 32'd1);
            check($sformatf("v%0d_s_awaddr", idx), s_axi_awaddr, v.exp_addr);
            check($sformatf("v%0d_s_wvalid", idx), {31'd0, s_axi_wvalid}, 32'd1);
            check($sformatf("v%0d_s_wdata", idx), s_axi_wdata, g ? m1_axi_wdata : m0_axi_wdata);
            check($sformatf("v%0d_s_arvalid_w", idx), {31'd0, s_axi_arvalid}, 32'd0);
            @(negedge clk);
            s_axi_awready = 1'b1; s_axi_wready = 1'b1;
            #1;
            check($sformatf("v%0d_awready_route", idx), {30'd0, m1_axi_awready, m0_axi_awready}, g ? 32'd2 : 32'd1);
            check($sformatf("v%0d_wready_route", idx), {30'd0, m1_axi_wready, m0_axi_wready}, g ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            check($sformatf("v%0d_wresp_quiet", idx), {29'd0, s_axi_arvalid, s_axi_awvalid, s_axi_wvalid}, 32'd0);
            @(negedge clk);
            s_axi_awready = 1'b0; s_axi_wready = 1'b0;
            if (g) begin m1_axi_awvalid = 1'b0; m1_axi_wvalid = 1'b0; end
            else   begin m0_axi_awvalid = 1'b0; m0_axi_wvalid = 1'b0; end
            s_axi_bvalid = 1'b1; s_axi_bresp = v.resp;
            #1;
            check($sformatf("v%0d_bvalid_route", idx), {30'd0, m1_axi_bvalid, m0_axi_bvalid}, g ? 32'd2 : 32'd1);
            check($sformatf("v%0d_bresp", idx), {30'd0, g ? m1_axi_bresp : m0_axi_bresp}, {30'd0, v.resp});
            check($sformatf("v%0d_s_bready", idx), {31'd0, s_axi_bready}, 32'd1);
            check($sformatf("v%0d_s_arvalid_b", idx), {31'd0, s_axi_arvalid}, 32'd0);
        end else begin
            check($sformatf("v%0d_state", idx), {29'd0, dbg_state}, 32'd1);
            check($sformatf("v%0d_s_arvalid", idx), {31'd0, s_axi_arvalid}, 32'd1);
            check($sformatf("v%0d_s_araddr", idx), s_axi_araddr, v.exp_addr);
            check($sformatf("v%0d_s_awvalid_r", idx), {31'd0, s_axi_awvalid}, 32'd0);
            @(negedge clk);
            s_axi_arready = 1'b1;
            #1;
            check($sformatf("v%0d_arready_route", idx), {30'd0, m1_axi_arready, m0_axi_arready}, g ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            s_axi_arready = 1'b0;
            if (g) m1_axi_arvalid = 1'b0; else m0_axi_arvalid = 1'b0;
            s_axi_rvalid = 1'b1; s_axi_rdata = v.rdata; s_axi_rresp = v.resp;
            #1;
            check($sformatf("v%0d_rvalid_route", idx), {30'd0, m1_axi_rvalid, m0_axi_rvalid}, g ? 32'd2 : 32'd1);
            check($sformatf("v%0d_rdata", idx), g ? m1_axi_rdata : m0_axi_rdata, v.rdata);
            check($sformatf("v%0d_rdata_other", idx), g ? m0_axi_rdata : m1_axi_rdata, 32'd0);
            check($sformatf("v%0d_rresp", idx), {30'd0, g ? m1_axi_rresp : m0_axi_rresp}, {30'd0, v.resp});
            check($sformatf("v%0d_s_rready", idx), {31'd0, s_axi_rready}, 32'd1);
        end
        @(posedge clk); #1;
        // Back in IDLE: responses are gated even while the slave still drives valid.
        check($sformatf("v%0d_done_state", idx), {29'd0, dbg_state}, 32'd0);
        check($sformatf("v%0d_done_gated", idx),
              {28'd0, m0_axi_rvalid, m1_axi_rvalid, m0_axi_bvalid, m1_axi_bvalid}, 32'd0);
        @(negedge clk);
        clear_slave();
        drop_masters();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar0, r0;

        // fields: m0_ar m0_aw m1_ar m1_aw | exp_g exp_wr exp_addr rdata resp
        // Reset leaves last_grant = m1, so contention goes m0, m1, m0, m1.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h1111_1111, 2'b00};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h2222_2222, 2'b00};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h3333_3333, 2'b00};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h4444_4444, 2'b00};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0204, 32'h0,         2'b10};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0204, 32'h0,         2'b00};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h0,         2'b01};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0204, 32'h0,         2'b00};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0,         2'b11};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h5A5A_A5A5, 2'b10};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 2'b11};

        m0_axi_araddr = 32'h0000_0010; m0_axi_awaddr = 32'h0000_0104;
        m1_axi_araddr = 32'h0000_0200; m1_axi_awaddr = 32'h0000_0204;
        m0_axi_wdata  = 32'h0A0A_0A0A; m1_axi_wdata  = 32'h1B1B_1B1B;
        m0_axi_wstrb  = 4'hF;          m1_axi_wstrb  = 4'hF;
        m0_axi_rready = 1'b1; m1_axi_rready = 1'b1;
        m0_axi_bready = 1'b1; m1_axi_bready = 1'b1;
        drop_masters();
        clear_slave();

        // ---- Reset: outputs quiet even with requests present ----
        m0_axi_arvalid = 1'b1; m1_axi_awvalid = 1'b1;
        s_axi_arready = 1'b1; s_axi_awready = 1'b1; s_axi_rvalid = 1'b1; s_axi_bvalid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        check("rst_valid_ready", {31'd0, |{s_axi_arvalid, s_axi_rready, s_axi_awvalid, s_axi_wvalid,
              s_axi_bready, m0_axi_arready, m0_axi_rvalid, m0_axi_awready, m0_axi_wready, m0_axi_bvalid,
              m1_axi_arready, m1_axi_rvalid, m1_axi_awready, m1_axi_wready, m1_axi_bvalid}}, 32'd0);
        check("rst_data", {31'd0, |{s_axi_araddr, s_axi_awaddr, s_axi_wdata, s_axi_wstrb,
              m0_axi_rdata, m0_axi_rresp, m0_axi_bresp, m1_axi_rdata, m1_axi_rresp, m1_axi_bresp}}, 32'd0);
        drop_masters();
        clear_slave();
        rst = 1'b0;

        // ---- Table ----
        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // ---- m1 write: AW first, W three cycles later, SLVERR passed back ----
        @(negedge clk);
        m1_axi_awaddr = 32'hFF00_0004; m1_axi_awvalid = 1'b1; m1_axi_wvalid = 1'b0;
        s_axi_awready = 1'b1; s_axi_wready = 1'b1;
        @(posedge clk); #1;
        check("split_state_waddr", {29'd0, dbg_state}, 32'd3);
        check("split_s_awvalid", {31'd0, s_axi_awvalid}, 32'd1);
        check("split_s_awaddr", s_axi_awaddr, 32'hFF00_0004);
        check("split_s_wvalid_early", {31'd0, s_axi_wvalid}, 32'd0);
        @(posedge clk); #1;
        check("split_aw_closed", {30'd0, s_axi_awvalid, m1_axi_awready}, 32'd0);
        check("split_still_waddr", {29'd0, dbg_state}, 32'd3);
        @(negedge clk);
        m1_axi_awvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m1_axi_wdata = 32'h0000_0041; m1_axi_wstrb = 4'h1; m1_axi_wvalid = 1'b1;
        #1;
        check("split_s_wvalid", {31'd0, s_axi_wvalid}, 32'd1);
        check("split_s_wdata", s_axi_wdata, 32'h0000_0041);
        check("split_s_wstrb", {28'd0, s_axi_wstrb}, 32'd1);
        check("split_wready_route", {30'd0, m1_axi_wready, m0_axi_wready}, 32'd2);
        @(posedge clk); #1;
        check("split_state_wresp", {29'd0, dbg_state}, 32'd4);
        @(negedge clk);
        m1_axi_wvalid = 1'b0; s_axi_awready = 1'b0; s_axi_wready = 1'b0;
        s_axi_bvalid = 1'b1; s_axi_bresp = 2'b10;
        #1;
        check("split_bvalid_route", {30'd0, m1_axi_bvalid, m0_axi_bvalid}, 32'd2);
        check("split_bresp", {30'd0, m1_axi_bresp}, 32'd2);
        @(posedge clk); #1;
        check("split_idle", {29'd0, dbg_state}, 32'd0);
        check("split_bvalid_gone", {31'd0, m1_axi_bvalid}, 32'd0);
        @(negedge clk);
        clear_slave();

        // ---- Reset asserted during R_DATA ----
        @(negedge clk);
        m0_axi_araddr = 32'h0000_0030; m0_axi_arvalid = 1'b1; s_axi_arready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        s_axi_arready = 1'b0; m0_axi_arvalid = 1'b0; m0_axi_rready = 1'b0;
        s_axi_rvalid = 1'b1; s_axi_rdata = 32'h7777_7777;
        #1;
        check("rstmid_pre_rvalid", {31'd0, m0_axi_rvalid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_state", {29'd0, dbg_state}, 32'd0);
        check("rstmid_quiet", {31'd0, |{s_axi_arvalid, s_axi_rready, s_axi_awvalid, s_axi_wvalid,
              s_axi_bready, m0_axi_arready, m0_axi_rvalid, m1_axi_rvalid, m0_axi_rdata}}, 32'd0);
        clear_slave();
        @(negedge clk);
        rst = 1'b0; m0_axi_rready = 1'b1;
        m0_axi_araddr = 32'h0000_0020;
        run_vec('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h1234_5678, 2'b00}, 20);

        // ---- Back-pressure: s_arready low 5 cycles, m0_rready low 3 cycles ----
        ar0 = ar_cnt; r0 = r_cnt;
        @(negedge clk);
        m0_axi_araddr = 32'h0000_0040; m0_axi_arvalid = 1'b1; s_axi_arready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check($sformatf("bp_ar_stall%0d", i), {29'd0, s_axi_arvalid, m0_axi_arready, dbg_state == 3'd1},
                  32'b101);
        end
        s_axi_arready = 1'b1;
        #1;
        check("bp_arready", {31'd0, m0_axi_arready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_axi_arready = 1'b0; m0_axi_arvalid = 1'b0; m0_axi_rready = 1'b0;
        s_axi_rvalid = 1'b1; s_axi_rdata = 32'hCAFE_0006; s_axi_rresp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("bp_r_hold%0d", i), {30'd0, m0_axi_rvalid, s_axi_rready}, 32'b10);
            check($sformatf("bp_rdata%0d", i), m0_axi_rdata, 32'hCAFE_0006);
        end
        @(negedge clk);
        m0_axi_rready = 1'b1;
        #1;
        check("bp_s_rready", {31'd0, s_axi_rready}, 32'd1);
        @(posedge clk); #1;
        check("bp_idle", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        clear_slave();
        @(negedge clk);
        check("bp_ar_count", ar_cnt - ar0, 32'd1);
        check("bp_r_count", r_cnt - r0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
